seg7_scan_driver: RTL and testbench
===================================

Name: seg7_scan_driver

Overview:
- Parametrised multi-digit 7-segment display driver; next generation of the team's single-digit combinational hex decoder.
- Holds a shadow copy of NUM_DIGITS 4-bit values and scans the digits one at a time (time-multiplexed anodes) at a programmable refresh rate.
- Adds per-digit blanking, decimal points, output polarity selection and an anti-ghosting blank slot.
- Sits between datapath or display registers and the board's shared segment and anode pins.

Parameters:
- NUM_DIGITS, 4, number of digits scanned; legal range 1..8.
- REFRESH_DIV, 100000, clk cycles per digit slot; minimum 2.
- ACTIVE_LOW, 1, 1 = seg, dp and an pins driven active-low; 0 = active-high.
- HEX_MODE, 1, 1 = nibbles 10..15 show A,b,C,d,E,F; 0 = nibbles 10..15 show all segments off.

Ports:
- clk  in  1  system clock.
- rst  in  1  synchronous reset, active-high.
- value  in  4*NUM_DIGITS  digit nibbles; digit k = value[4k+3:4k]; digit 0 is rightmost.
- dp_in  in  NUM_DIGITS  decimal point request per digit.
- blank_in  in  NUM_DIGITS  1 = digit dark.
- load  in  1  capture value, dp_in and blank_in into the shadow registers.
- seg  out  7  {g,f,e,d,c,b,a}.
- dp  out  1  decimal point pin.
- an  out  NUM_DIGITS  anode enables; one-hot at most.
- digit_idx  out  clog2(NUM_DIGITS), min 1  digit currently being scanned (the unregistered idx).

Behaviour:
- One clock domain: clk. Reset is synchronous, active-high, on rst.
- Reset is sampled only on the rising edge of clk. On that edge:
  - divider cnt <= 0, idx <= 0.
  - All shadow registers <= 0.
  - Output registers <= all inactive: an all off, seg all off, dp off; polarity is applied, so with ACTIVE_LOW=1 every pin is 1.
  - digit_idx = 0.
- Reset asserted mid-scan or mid-load overrides every other action on that edge.
- Shadow load: on an edge with load=1 and rst=0, the shadow registers capture value, dp_in and blank_in. With load=0 the inputs are ignored, so there is no tearing.
- Divider: cnt counts 0..REFRESH_DIV-1 and wraps to 0.
- Scan index: on the edge where cnt==REFRESH_DIV-1, idx advances by 1. It wraps from NUM_DIGITS-1 to 0. With NUM_DIGITS=1, idx stays 0.
- Output register: seg, dp and an are all registered and computed from the pre-edge idx, cnt and shadow contents. Latency is 1 cycle from idx/shadow to pins, so load to visible = 2 cycles.
- Anti-ghost slot: if the pre-edge cnt==REFRESH_DIV-1, the next cycle drives an all inactive and seg/dp inactive. Each digit is therefore lit REFRESH_DIV-1 of every REFRESH_DIV cycles.
- Lit digit: an has the single bit idx active.
  - If shadow blank[idx]=1: the anode is still active but seg and dp are off.
  - Otherwise seg = decode(nibble[idx]) and dp = shadow dp[idx].
- Decode table, logical active-high {g..a}:
  - 0=3F, 1=06, 2=5B, 3=4F, 4=66, 5=6D, 6=7D, 7=07, 8=7F, 9=6F.
  - A=77, b=7C, C=39, d=5E, E=79, F=71.
  - HEX_MODE=0: nibbles 10..15 give 00.
- Polarity: when ACTIVE_LOW=1, the final seg, dp and an are bitwise inverted after all logic above.
- Simultaneous load and idx advance on one edge: both take effect. The new shadow is used from the next output register update.
- Invariant: $onehot0(an logical) holds every cycle.

Test Plan:
- Reset: NUM_DIGITS=4, REFRESH_DIV=4, ACTIVE_LOW=1; hold rst 3 cycles, load=1, value=16'h1234 -> while rst=1: seg=7'h7F, an=4'hF, dp=1, digit_idx=0. Shadow not loaded.
- Scan order: load value=16'h1234 (dp_in=0, blank_in=0), then release -> an (logical) cycles digit0,1,2,3,0, with 3 lit cycles per digit plus 1 blank cycle. Logical seg: 4'→66, 3→4F, 2→5B, 1→06. Pins are inverted: digit0 an=4'b1110, seg=7'h19.
- Shadow isolation: after loading 16'hABCD, change value to 16'h0000 with load=0 for 40 cycles -> digits still show d, C, b, A (logical 5E, 39, 7C, 77). Pulse load -> 0s (logical 3F) appear 2 cycles later on the lit digit.
- Blank/dp/HEX_MODE: HEX_MODE=0, value=16'hF905, blank_in=4'b0100, dp_in=4'b0001 -> digit0: logical seg 6D, dp on. Digit1: 3F. Digit2: anode active, seg 00, dp off. Digit3: seg 00.
- Wrap and reset mid-scan: NUM_DIGITS=3, REFRESH_DIV=2 -> idx sequence 0,0,1,1,2,2,0. Assert rst while idx=2 -> next cycle idx=0, cnt=0, all pins inactive. After release, digit0 lights with shadow=0 (logical seg 3F).
- ACTIVE_LOW=0 and NUM_DIGITS=1: value=4'h8, dp_in=1 -> an=1 for 1 of every REFRESH_DIV cycles off, otherwise on. seg=7'h7F, dp=1 while lit. digit_idx is constant 0.

Source files
------------

// File: rtl/seg7_scan_if.sv
// seg7_scan_if: digit data/load inputs and multiplexed segment/anode pins of the scan driver
interface seg7_scan_if #(parameter int NUM_DIGITS = 4);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  logic [4*NUM_DIGITS-1:0] value;
  logic [NUM_DIGITS-1:0] dp_in;
  logic [NUM_DIGITS-1:0] blank_in;
  logic load;
  logic [6:0] seg;
  logic dp;
  logic [NUM_DIGITS-1:0] an;
  logic [IW-1:0] digit_idx;
  modport master(output value, dp_in, blank_in, load, input seg, dp, an, digit_idx);
  modport slave(input value, dp_in, blank_in, load, output seg, dp, an, digit_idx);
endinterface

// File: rtl/seg7_scan_driver.sv
// seg7_scan_driver: time-multiplexed multi-digit 7-segment driver with shadow registers and anti-ghost slot
module seg7_scan_driver #(
  parameter int NUM_DIGITS  = 4,
  parameter int REFRESH_DIV = 100000,
  parameter int ACTIVE_LOW  = 1,
  parameter int HEX_MODE    = 1
) (
  input logic clk,
  input logic rst,
  seg7_scan_if.slave bus
);
  localparam int IW = NUM_DIGITS > 1 ? $clog2(NUM_DIGITS) : 1;
  localparam int CW = $clog2(REFRESH_DIV);
  localparam logic P = ACTIVE_LOW != 0;
  localparam logic [6:0] DEC [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                                      7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  logic [CW-1:0] cnt;
  logic [IW-1:0] idx;
  logic [4*NUM_DIGITS-1:0] sh_val;
  logic [NUM_DIGITS-1:0] sh_dp, sh_bl, an_q, an_d;
  logic [6:0] seg_q, seg_d;
  logic dp_q, dp_d, last, dark;
  logic [3:0] nib;
  // the final count of each slot is the dark anti-ghost cycle
  always_comb begin
    last = cnt == CW'(REFRESH_DIV - 1);
    nib = sh_val[{idx, 2'b00} +: 4];
    dark = last || sh_bl[idx];
    seg_d = (dark || (HEX_MODE == 0 && nib > 4'd9)) ? 7'h00 : DEC[nib];
    dp_d = !dark && sh_dp[idx];
    an_d = last ? '0 : NUM_DIGITS'(1) << idx;
  end
  always_ff @(posedge clk) begin
    if (rst) begin
      cnt <= '0;
      idx <= '0;
      sh_val <= '0;
      sh_dp <= '0;
      sh_bl <= '0;
      seg_q <= {7{P}};
      dp_q <= P;
      an_q <= {NUM_DIGITS{P}};
    end else begin
      cnt <= last ? '0 : cnt + 1'b1;
      if (last) idx <= (idx == IW'(NUM_DIGITS - 1)) ? '0 : idx + 1'b1;
      if (bus.load) begin
        sh_val <= bus.value;
        sh_dp <= bus.dp_in;
        sh_bl <= bus.blank_in;
      end
      seg_q <= seg_d ^ {7{P}};
      dp_q <= dp_d ^ P;
      an_q <= an_d ^ {NUM_DIGITS{P}};
    end
  end
  assign bus.seg = seg_q;
  assign bus.dp = dp_q;
  assign bus.an = an_q;
  assign bus.digit_idx = idx;
endmodule

// File: tb/tb_seg7_scan_driver.sv
// tb_seg7_scan_driver: three driver configurations under shared random stimulus, checked against a slot-arithmetic model
module tb_seg7_scan_driver;
  logic clk = 0;
  logic rst;
  always #5 clk = ~clk;
  seg7_scan_if #(.NUM_DIGITS(4)) ia();
  seg7_scan_if #(.NUM_DIGITS(3)) ib();
  seg7_scan_if #(.NUM_DIGITS(1)) ic();
  seg7_scan_driver #(.NUM_DIGITS(4), .REFRESH_DIV(4), .ACTIVE_LOW(1), .HEX_MODE(1)) dut_a (.clk(clk), .rst(rst), .bus(ia.slave));
  seg7_scan_driver #(.NUM_DIGITS(3), .REFRESH_DIV(2), .ACTIVE_LOW(1), .HEX_MODE(0)) dut_b (.clk(clk), .rst(rst), .bus(ib.slave));
  seg7_scan_driver #(.NUM_DIGITS(1), .REFRESH_DIV(3), .ACTIVE_LOW(0), .HEX_MODE(1)) dut_c (.clk(clk), .rst(rst), .bus(ic.slave));
  logic [6:0] tbl [16] = '{7'h3F, 7'h06, 7'h5B, 7'h4F, 7'h66, 7'h6D, 7'h7D, 7'h07,
                           7'h7F, 7'h6F, 7'h77, 7'h7C, 7'h39, 7'h5E, 7'h79, 7'h71};
  int passed = 0, total = 0;
  logic load;
  logic [31:0] vv;
  logic [7:0] dd, bb;
  int n [3];
  logic [31:0] sv [3];
  logic [7:0] sd [3], sb [3];
  logic [31:0] es [3], ea [3], ed [3], ei [3];
  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got === exp) passed++;
    else $display("FAIL %s: got %0h expected %0h at %0t", tag, got, exp, $time);
  endtask
  task automatic drive();
    ia.value = vv[15:0]; ib.value = vv[11:0]; ic.value = vv[3:0];
    ia.dp_in = dd[3:0]; ib.dp_in = dd[2:0]; ic.dp_in = dd[0];
    ia.blank_in = bb[3:0]; ib.blank_in = bb[2:0]; ic.blank_in = bb[0];
    ia.load = load; ib.load = load; ic.load = load;
  endtask
  // digit i is lit for slot positions 0..rd-2 of each rd-cycle slot; position rd-1 is dark
  task automatic step(input int k, input int nd, input int rd, input bit hx);
    int c, i;
    logic [3:0] nib;
    if (rst) begin
      n[k] = 0; sv[k] = 0; sd[k] = 0; sb[k] = 0;
      es[k] = 0; ea[k] = 0; ed[k] = 0;
    end else begin
      c = n[k] % rd;
      i = (n[k] / rd) % nd;
      nib = sv[k][4*i +: 4];
      ea[k] = (c == rd - 1) ? 0 : (1 << i);
      if (c == rd - 1 || sb[k][i]) begin
        es[k] = 0; ed[k] = 0;
      end else begin
        es[k] = (!hx && nib > 9) ? 0 : 32'(tbl[nib]);
        ed[k] = 32'(sd[k][i]);
      end
      if (load) begin
        sv[k] = vv; sd[k] = dd; sb[k] = bb;
      end
      n[k]++;
    end
    ei[k] = (n[k] / rd) % nd;
  endtask
  task automatic cycle();
    @(posedge clk);
    step(0, 4, 4, 1);
    step(1, 3, 2, 0);
    step(2, 1, 3, 1);
    @(negedge clk);
    chk("a_seg", 32'(ia.seg), es[0] ^ 32'h7F);
    chk("a_an", 32'(ia.an), ea[0] ^ 32'hF);
    chk("a_dp", 32'(ia.dp), ed[0] ^ 32'h1);
    chk("a_idx", 32'(ia.digit_idx), ei[0]);
    chk("a_onehot", 32'($onehot0(~ia.an)), 32'h1);
    chk("b_seg", 32'(ib.seg), es[1] ^ 32'h7F);
    chk("b_an", 32'(ib.an), ea[1] ^ 32'h7);
    chk("b_dp", 32'(ib.dp), ed[1] ^ 32'h1);
    chk("b_idx", 32'(ib.digit_idx), ei[1]);
    chk("c_seg", 32'(ic.seg), es[2]);
    chk("c_an", 32'(ic.an), ea[2]);
    chk("c_dp", 32'(ic.dp), ed[2]);
    chk("c_idx", 32'(ic.digit_idx), ei[2]);
  endtask
  initial begin
    rst = 1; load = 1; vv = 32'h1234; dd = 0; bb = 0;
    drive();
    for (int i = 0; i < 3; i++) begin
      cycle();
      chk("rst_seg", 32'(ia.seg), 32'h7F);
      chk("rst_an", 32'(ia.an), 32'hF);
      chk("rst_dp", 32'(ia.dp), 32'h1);
      chk("rst_idx", 32'(ia.digit_idx), 32'h0);
    end
    rst = 0; load = 1; vv = 32'h1234;
    drive();
    cycle();
    load = 0; vv = 32'h0;
    drive();
    for (int i = 0; i < 20; i++) cycle();
    vv = 32'hF905; bb = 8'b0100; dd = 8'b0001; load = 1;
    drive();
    cycle();
    load = 0;
    drive();
    for (int i = 0; i < 20; i++) cycle();
    for (int i = 0; i < 800; i++) begin
      rst = ($urandom % 120) == 0;
      load = ($urandom % 6) == 0;
      vv = $urandom;
      dd = 8'($urandom);
      bb = 8'($urandom % 4 == 0 ? $urandom : 0);
      drive();
      cycle();
    end
    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end
endmodule
